// File: rtl/conv_seq_pkg.sv
// Shared types and geometry helpers for the convolution frame sequencer and
// the layer-chain FSM that sizes downstream frames with the same arithmetic.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_t;

  // Output extent of one convolution axis; pad_total is the sum of both sides.
  function automatic int conv_out_dim(input int in_dim, input int k, input int dil,
                                      input int pad_total, input int stride);
    return (in_dim + pad_total - dil * (k - 1) - 1) / stride + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Control/status bundle between the layer-chain side (master) and the
// frame sequencer (slave).
interface conv_frame_sequencer_if #(
  parameter int FRAME_CNT_WIDTH = 16
);
  logic                       start;
  logic                       abort;
  logic                       pix_rd;
  logic                       pe_ack;
  logic                       lb_en;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic                       timeout;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

  modport master (
    output start, abort, pix_rd, pe_ack,
    input  lb_en, busy, done, err, timeout, frame_cnt
  );

  modport slave (
    input  start, abort, pix_rd, pe_ack,
    output lb_en, busy, done, err, timeout, frame_cnt
  );
endinterface

// File: rtl/conv_frame_sequencer_sat_counter.sv
// Up-counter with synchronous clear that holds at LIMIT instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o    = cnt_q;
  assign at_limit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for one convolution layer: arms the line buffer,
// counts consumed pixels and acknowledged windows, and pulses done per frame.
// Optional drain watchdog: define CONV_SEQ_WATCHDOG_EN.
module conv_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IN_WIDTH        = 512,
  parameter int IN_HEIGHT       = 256,
  parameter int KERNEL_0        = 3,
  parameter int KERNEL_1        = 3,
  parameter int DILATION_0      = 1,
  parameter int DILATION_1      = 1,
  parameter int PADDING_0       = 1,
  parameter int PADDING_1       = 1,
  parameter int STRIDE_0        = 1,
  parameter int STRIDE_1        = 1,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int WDOG_CYCLES     = 65536
) (
  input logic                   clk,
  input logic                   rst,
  conv_frame_sequencer_if.slave bus
);

  // Rows are padded at the bottom only; columns on both sides.
  localparam int OUT_H   = conv_out_dim(IN_HEIGHT, KERNEL_0, DILATION_0, PADDING_0, STRIDE_0);
  localparam int OUT_W   = conv_out_dim(IN_WIDTH, KERNEL_1, DILATION_1, 2 * PADDING_1, STRIDE_1);
  localparam int IN_PIX  = IN_WIDTH * IN_HEIGHT;
  localparam int OUT_PIX = OUT_H * OUT_W;
  localparam int IN_CW   = cnt_width(IN_PIX);
  localparam int OUT_CW  = cnt_width(OUT_PIX);

  if (OUT_H < 1 || OUT_W < 1) begin : g_bad_geometry
    $error("conv_frame_sequencer: output frame is empty (OUT_H=%0d OUT_W=%0d)", OUT_H, OUT_W);
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("conv_frame_sequencer: WDOG_CYCLES must be at least 1");
  end

  seq_state_t                 state_q, state_d;
  logic                       lb_en_q, busy_q, done_q, err_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

  logic [IN_CW-1:0]  in_cnt;
  logic [OUT_CW-1:0] out_cnt;
  logic              in_full, out_full;
  logic              cnt_clr, in_inc, out_inc;
  logic              in_last, out_last;
  logic              start_ok, proto_err, wdog_expire;

  assign start_ok = (state_q == SEQ_IDLE) && bus.start && !bus.abort;
  assign cnt_clr  = bus.abort || ((state_q == SEQ_IDLE) && bus.start);
  assign in_inc   = (state_q == SEQ_RUN) && bus.pix_rd;
  assign out_inc  = ((state_q == SEQ_RUN) || (state_q == SEQ_DRAIN)) && bus.pe_ack;

  // "last" means this cycle's pulse brings the count to its frame total.
  assign in_last  = in_inc && (in_cnt == IN_CW'(IN_PIX - 1));
  assign out_last = out_inc && (out_cnt == OUT_CW'(OUT_PIX - 1));

  assign proto_err = (bus.pix_rd && ((state_q != SEQ_RUN) || in_full)) ||
                     (bus.pe_ack && ((state_q == SEQ_IDLE) || out_full));

  sat_counter #(.WIDTH(IN_CW), .LIMIT(IN_PIX)) u_in_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .inc_i      (in_inc),
    .count_o    (in_cnt),
    .at_limit_o (in_full)
  );

  sat_counter #(.WIDTH(OUT_CW), .LIMIT(OUT_PIX)) u_out_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .inc_i      (out_inc),
    .count_o    (out_cnt),
    .at_limit_o (out_full)
  );

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = SEQ_IDLE;
    end else begin
      unique case (state_q)
        SEQ_IDLE:  if (bus.start) state_d = SEQ_RUN;
        SEQ_RUN: begin
          if (in_last) state_d = (out_last || out_full) ? SEQ_DONE : SEQ_DRAIN;
        end
        SEQ_DRAIN: begin
          if (out_last)         state_d = SEQ_DONE;
          else if (wdog_expire) state_d = SEQ_IDLE;
        end
        SEQ_DONE:  state_d = SEQ_IDLE;
        default:   state_d = SEQ_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      lb_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lb_en_q <= (state_d == SEQ_RUN);
      busy_q  <= (state_d == SEQ_RUN) || (state_d == SEQ_DRAIN);
      done_q  <= (state_d == SEQ_DONE);
      if (proto_err)     err_q <= 1'b1;
      else if (start_ok) err_q <= 1'b0;
      if ((state_q == SEQ_DONE) && !bus.abort) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int WD_W = cnt_width(WDOG_CYCLES);

  logic [WD_W-1:0] wdog_q;
  logic            timeout_q;

  // Held at full load outside DRAIN, so entering DRAIN starts a fresh count.
  assign wdog_expire = (state_q == SEQ_DRAIN) && !bus.pe_ack && (wdog_q == WD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= WD_W'(WDOG_CYCLES);
      timeout_q <= 1'b0;
    end else begin
      if ((state_q != SEQ_DRAIN) || bus.pe_ack) wdog_q <= WD_W'(WDOG_CYCLES);
      else if (wdog_q != '0)                    wdog_q <= wdog_q - 1'b1;
      if (wdog_expire && !bus.abort) timeout_q <= 1'b1;
      else if (start_ok)             timeout_q <= 1'b0;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.lb_en     = lb_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
